// File: rtl/ebi_slave.sv
// EBI bus responder: synchronises MCU strobes, writes a control register bank,
// and answers reads from the registers, a status word and a fabric-fed sample FIFO.
module ebi_slave #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 16,
    parameter int NREGS      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STAT_ADDR  = 'h100,
    parameter int FIFO_ADDR  = 'h101
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       ebi_data_in,
    output logic [DATA_W-1:0]       ebi_data_out,
    output logic                    ebi_data_oe,
    input  logic [ADDR_W-1:0]       ebi_addr,
    input  logic                    ebi_wr,
    input  logic                    ebi_rd,
    input  logic                    ebi_cs,
    output logic [NREGS*DATA_W-1:0] ctrl_regs,
    output logic                    reg_wr_pulse,
    output logic [2:0]              reg_wr_idx,
    input  logic [DATA_W-1:0]       sample_data,
    input  logic                    sample_valid,
    output logic                    sample_ready
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Strobe synchronisers; bit 0 is the first stage. Reset to 1 so a strobe
    // already high at reset release never produces an edge.
    logic [2:0] wr_sync;
    logic [2:0] rd_sync;
    logic       wr_a;
    logic       rd_a;
    logic       wr_edge;
    logic       rd_edge;
    logic       rd_act;

    assign wr_a = ebi_cs & ebi_wr;
    assign rd_a = ebi_cs & ebi_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sync <= 3'b111;
            rd_sync <= 3'b111;
        end else begin
            wr_sync <= {wr_sync[1:0], wr_a};
            rd_sync <= {rd_sync[1:0], rd_a};
        end
    end

    assign wr_edge = wr_sync[1] & ~wr_sync[2];
    assign rd_edge = rd_sync[1] & ~rd_sync[2];
    // A write edge coinciding with a read edge wins; the read is dropped.
    assign rd_act  = rd_edge & ~wr_edge;

    // Address decode
    logic             addr_is_reg;
    logic             addr_is_stat;
    logic             addr_is_fifo;
    logic [IDX_W-1:0] reg_idx;

    assign addr_is_reg  = ebi_addr < ADDR_W'(NREGS);
    assign addr_is_stat = ebi_addr == ADDR_W'(STAT_ADDR);
    assign addr_is_fifo = ebi_addr == ADDR_W'(FIFO_ADDR);
    assign reg_idx      = ebi_addr[IDX_W-1:0];

    // Control register bank
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            reg_wr_pulse <= 1'b0;
            reg_wr_idx   <= 3'd0;
        end else begin
            reg_wr_pulse <= 1'b0;
            if (wr_edge && addr_is_reg) begin
                regs[reg_idx] <= ebi_data_in;
                reg_wr_pulse  <= 1'b1;
                reg_wr_idx    <= 3'(reg_idx);
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign ctrl_regs[g*DATA_W +: DATA_W] = regs[g];
    end

    // Sample FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              fifo_rd;
    logic              pop;
    logic              underflow;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = count == CNT_W'(FIFO_DEPTH);
    assign empty        = count == '0;
    assign sample_ready = ~full;
    // Push is gated by the registered full flag, so a pop in the same
    // cycle does not open space for a push until the next cycle.
    assign push         = sample_valid & ~full;
    assign fifo_rd      = rd_act & addr_is_fifo;
    assign pop          = fifo_rd & ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (wr_edge && addr_is_stat && ebi_data_in[2]) begin
            underflow <= 1'b0;
        end else if (fifo_rd && empty) begin
            underflow <= 1'b1;
        end
    end

    // Read data path
    logic [15:0]       status16;
    logic [DATA_W-1:0] rd_word;

    assign status16 = {8'(count), 5'b0, underflow, full, empty};

    always_comb begin
        rd_word = '0;
        if (addr_is_reg) begin
            rd_word = regs[reg_idx];
        end else if (addr_is_stat) begin
            rd_word = DATA_W'(status16);
        end else if (addr_is_fifo && !empty) begin
            rd_word = mem[rd_ptr];
        end
    end

    // Output enable holds while the synchronised read strobe stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            ebi_data_out <= '0;
            ebi_data_oe  <= 1'b0;
        end else begin
            if (rd_act) begin
                ebi_data_out <= rd_word;
            end
            ebi_data_oe <= rd_act | (ebi_data_oe & rd_sync[1]);
        end
    end

endmodule

// File: tb/tb_ebi_slave.sv
// Directed bench for ebi_slave: expected read/write responses are queued by the
// drivers and compared by a monitor when the DUT presents them.
module tb_ebi_slave;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam logic [ADDR_W-1:0] STAT = 21'h100;
    localparam logic [ADDR_W-1:0] FIFO = 21'h101;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [DATA_W-1:0]       ebi_data_in;
    logic [DATA_W-1:0]       ebi_data_out;
    logic                    ebi_data_oe;
    logic [ADDR_W-1:0]       ebi_addr;
    logic                    ebi_wr;
    logic                    ebi_rd;
    logic                    ebi_cs;
    logic [NREGS*DATA_W-1:0] ctrl_regs;
    logic                    reg_wr_pulse;
    logic [2:0]              reg_wr_idx;
    logic [DATA_W-1:0]       sample_data;
    logic                    sample_valid;
    logic                    sample_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_exp_q[$];
    logic [18:0] wr_exp_q[$];

    ebi_slave dut (
        .clk          (clk),
        .reset        (reset),
        .ebi_data_in  (ebi_data_in),
        .ebi_data_out (ebi_data_out),
        .ebi_data_oe  (ebi_data_oe),
        .ebi_addr     (ebi_addr),
        .ebi_wr       (ebi_wr),
        .ebi_rd       (ebi_rd),
        .ebi_cs       (ebi_cs),
        .ctrl_regs    (ctrl_regs),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_wr_idx   (reg_wr_idx),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    logic oe_prev = 1'b0;
    logic pulse_prev = 1'b0;

    always @(negedge clk) begin
        logic [18:0] we;
        if (!reset) begin
            if (ebi_data_oe && !oe_prev) begin
                if (rd_exp_q.size() == 0) begin
                    check("unexpected_read", 32'(ebi_data_out), 32'hDEAD_BEEF);
                end else begin
                    check("read_data", 32'(ebi_data_out), 32'(rd_exp_q.pop_front()));
                end
            end
            if (reg_wr_pulse) begin
                check("pulse_width", 32'(pulse_prev), 32'd0);
                if (wr_exp_q.size() == 0) begin
                    check("unexpected_write", 32'(reg_wr_idx), 32'hDEAD_BEEF);
                end else begin
                    we = wr_exp_q.pop_front();
                    check("write_idx", 32'(reg_wr_idx), 32'(we[18:16]));
                    check("write_reg", 32'(ctrl_regs[int'(we[18:16])*16 +: 16]), 32'(we[15:0]));
                end
            end
        end
        oe_prev    <= ebi_data_oe;
        pulse_prev <= reg_wr_pulse;
    end

    // Driver tasks
    task automatic ebi_write(input logic [ADDR_W-1:0] addr, input logic [15:0] data);
        if (addr < NREGS) wr_exp_q.push_back({3'(addr), data});
        @(negedge clk);
        ebi_addr = addr; ebi_data_in = data; ebi_cs = 1'b1; ebi_wr = 1'b1;
        repeat (5) @(negedge clk);
        ebi_cs = 1'b0; ebi_wr = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic ebi_read(input logic [ADDR_W-1:0] addr, input logic [15:0] exp);
        rd_exp_q.push_back(exp);
        @(negedge clk);
        ebi_addr = addr; ebi_cs = 1'b1; ebi_rd = 1'b1;
        repeat (5) @(negedge clk);
        ebi_cs = 1'b0; ebi_rd = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic sample_push(input logic [15:0] d);
        @(negedge clk);
        sample_data = d; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Stimulus
    initial begin
        int oe_seen;
        reset = 1'b1;
        ebi_data_in = '0; ebi_addr = '0; ebi_wr = 1'b0; ebi_rd = 1'b0; ebi_cs = 1'b0;
        sample_data = '0; sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        check("rst_regs", 32'(ctrl_regs != '0), 32'd0);
        check("rst_oe", 32'(ebi_data_oe), 32'd0);
        check("rst_data_out", 32'(ebi_data_out), 32'd0);
        check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
        check("rst_idx", 32'(reg_wr_idx), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        repeat (5) @(negedge clk);

        // 1: write timing
        @(negedge clk);
        wr_exp_q.push_back({3'd1, 16'h000F});
        ebi_addr = 21'd1; ebi_data_in = 16'h000F; ebi_cs = 1'b1; ebi_wr = 1'b1;
        @(negedge clk);
        check("t1_pulse_e1", 32'(reg_wr_pulse), 32'd0);
        @(negedge clk);
        check("t1_reg_e2", 32'(ctrl_regs[31:16]), 32'h0);
        check("t1_pulse_e2", 32'(reg_wr_pulse), 32'd0);
        @(negedge clk);
        check("t1_reg_e3", 32'(ctrl_regs[31:16]), 32'h000F);
        check("t1_pulse_e3", 32'(reg_wr_pulse), 32'd1);
        check("t1_idx_e3", 32'(reg_wr_idx), 32'd1);
        @(negedge clk);
        check("t1_pulse_e4", 32'(reg_wr_pulse), 32'd0);
        @(negedge clk);
        ebi_cs = 1'b0; ebi_wr = 1'b0;
        repeat (4) @(negedge clk);

        // 2: read timing
        @(negedge clk);
        rd_exp_q.push_back(16'h000F);
        ebi_addr = 21'd1; ebi_cs = 1'b1; ebi_rd = 1'b1;
        @(negedge clk);
        check("t2_oe_e1", 32'(ebi_data_oe), 32'd0);
        @(negedge clk);
        check("t2_oe_e2", 32'(ebi_data_oe), 32'd0);
        @(negedge clk);
        check("t2_oe_e3", 32'(ebi_data_oe), 32'd1);
        check("t2_data_e3", 32'(ebi_data_out), 32'h000F);
        repeat (2) @(negedge clk);
        ebi_cs = 1'b0; ebi_rd = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_oe_hold", 32'(ebi_data_oe), 32'd1);
        @(negedge clk);
        check("t2_oe_drop", 32'(ebi_data_oe), 32'd0);
        check("t2_data_kept", 32'(ebi_data_out), 32'h000F);
        repeat (3) @(negedge clk);

        // Register bank boundaries and unmapped addresses
        ebi_write(21'd7, 16'hBEEF);
        ebi_write(21'd8, 16'h5555);
        ebi_write(21'h50, 16'h6666);
        ebi_read(21'd7, 16'hBEEF);
        ebi_read(21'd8, 16'h0000);
        ebi_read(21'h50, 16'h0000);

        // 3: FIFO basic
        sample_push(16'h00A1);
        sample_push(16'h00A2);
        ebi_read(STAT, 16'h0200);
        ebi_read(FIFO, 16'h00A1);
        ebi_read(FIFO, 16'h00A2);
        ebi_read(STAT, 16'h0001);

        // 4: underflow set and clear
        ebi_read(FIFO, 16'h0000);
        ebi_read(STAT, 16'h0005);
        ebi_write(STAT, 16'h0004);
        ebi_read(STAT, 16'h0001);

        // 5: full FIFO
        for (int i = 0; i < 16; i++) sample_push(16'h00B0 + 16'(i));
        check("t5_ready_full", 32'(sample_ready), 32'd0);
        ebi_read(STAT, 16'h1002);
        sample_push(16'h00EE);
        @(negedge clk);
        rd_exp_q.push_back(16'h00B0);
        sample_data = 16'h00CC; sample_valid = 1'b1;
        ebi_addr = FIFO; ebi_cs = 1'b1; ebi_rd = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_ready_after_pop", 32'(sample_ready), 32'd1);
        @(negedge clk);
        check("t5_ready_refill", 32'(sample_ready), 32'd0);
        sample_valid = 1'b0;
        @(negedge clk);
        ebi_cs = 1'b0; ebi_rd = 1'b0;
        repeat (5) @(negedge clk);
        ebi_read(STAT, 16'h1002);
        for (int i = 1; i < 16; i++) ebi_read(FIFO, 16'h00B0 + 16'(i));
        ebi_read(FIFO, 16'h00CC);
        ebi_read(STAT, 16'h0001);

        // 6: write/read conflict
        @(negedge clk);
        wr_exp_q.push_back({3'd2, 16'h1234});
        ebi_addr = 21'd2; ebi_data_in = 16'h1234; ebi_cs = 1'b1; ebi_wr = 1'b1; ebi_rd = 1'b1;
        oe_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 4) begin ebi_cs = 1'b0; ebi_wr = 1'b0; ebi_rd = 1'b0; end
            oe_seen += int'(ebi_data_oe);
        end
        check("t6_conflict_oe", 32'(oe_seen), 32'd0);
        check("t6_conflict_reg", 32'(ctrl_regs[47:32]), 32'h1234);
        ebi_read(21'd2, 16'h1234);

        // 6: reset mid-read, strobe still held across release
        @(negedge clk);
        rd_exp_q.push_back(16'h1234);
        ebi_addr = 21'd2; ebi_cs = 1'b1; ebi_rd = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_oe_before_rst", 32'(ebi_data_oe), 32'd1);
        #2 reset = 1'b1;
        @(negedge clk);
        check("t6_rst_oe", 32'(ebi_data_oe), 32'd0);
        check("t6_rst_data", 32'(ebi_data_out), 32'd0);
        check("t6_rst_regs", 32'(ctrl_regs != '0), 32'd0);
        check("t6_rst_idx", 32'(reg_wr_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        oe_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            oe_seen += int'(ebi_data_oe);
        end
        check("t6_held_strobe_ignored", 32'(oe_seen), 32'd0);
        ebi_cs = 1'b0; ebi_rd = 1'b0;
        repeat (5) @(negedge clk);
        ebi_read(21'd2, 16'h0000);
        ebi_read(STAT, 16'h0001);

        repeat (5) @(negedge clk);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
